// File: rtl/uart_line_editor.sv
// uart_line_editor: echoes typed characters with backspace editing, then replays the finished line on CR.
module uart_line_editor #(
  parameter int LINE_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              line_done,
  output logic [LINE_W:0]   line_len,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, DECODE, EMIT, REPLAY, DONE} state_t;
  localparam logic [LINE_W:0] FULL = {1'b1, {LINE_W{1'b0}}};
  state_t            state;
  logic [7:0]        line_buf [2**LINE_W];
  logic [7:0]        data;
  logic [LINE_W:0]   count;
  logic [LINE_W+1:0] ri;
  logic [LINE_W+1:0] cnt_x;
  logic [2:0][7:0]   q;
  logic [1:0]        qi;
  logic [1:0]        qn;
  logic              cr;
  logic              printable;
  logic              erase;
  logic              store;
  assign printable = data >= 8'h20 && data <= 8'h7e;
  assign erase     = data == 8'h08 || data == 8'h7f;
  assign store     = state == DECODE && printable && count != FULL;
  assign cnt_x     = {1'b0, count};
  assign rd_uart   = reset_n && state == IDLE && !rx_empty;
  assign wr_uart   = (state == EMIT || state == REPLAY) && !tx_full;
  assign line_done = state == DONE;
  assign busy      = state != IDLE;
  // Replay walks the buffer then appends CR LF once the index passes count.
  assign w_data = state == EMIT   ? q[qi] :
                  state == REPLAY ? (ri < cnt_x ? line_buf[ri[LINE_W-1:0]] : ri == cnt_x ? 8'h0d : 8'h0a) :
                  8'h00;
  always_ff @(posedge clk)
    if (store) line_buf[count[LINE_W-1:0]] <= data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      data     <= 8'h00;
      count    <= '0;
      line_len <= '0;
      ri       <= '0;
      q        <= '0;
      qi       <= 2'd0;
      qn       <= 2'd0;
      cr       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!rx_empty) begin
          data  <= r_data;
          state <= DECODE;
        end
        DECODE: begin
          qi    <= 2'd0;
          cr    <= 1'b0;
          state <= EMIT;
          if (printable) begin
            q  <= {16'h0, count != FULL ? data : 8'h07};
            qn <= 2'd1;
            if (count != FULL) count <= count + 1'b1;
          end else if (erase) begin
            q  <= count != 0 ? {8'h08, 8'h20, 8'h08} : {16'h0, 8'h07};
            qn <= count != 0 ? 2'd3 : 2'd1;
            if (count != 0) count <= count - 1'b1;
          end else if (data == 8'h0d) begin
            q  <= {8'h00, 8'h0a, 8'h0d};
            qn <= 2'd2;
            cr <= 1'b1;
          end else state <= IDLE;
        end
        EMIT: if (!tx_full) begin
          qi <= qi + 2'd1;
          if (qi == qn - 2'd1) begin
            state <= cr ? REPLAY : IDLE;
            ri    <= '0;
          end
        end
        REPLAY: if (!tx_full) begin
          ri <= ri + 1'b1;
          if (ri == cnt_x + 1'b1) begin
            line_len <= count;
            state    <= DONE;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_line_editor.sv
// tb_uart_line_editor: scoreboard bench for the line editor at LINE_W=5 and LINE_W=2.
module tb_uart_line_editor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty [2];
  logic       tx_full [2];
  logic       rd_uart [2];
  logic       wr_uart [2];
  logic       line_done [2];
  logic       busy [2];
  logic [7:0] r_data [2];
  logic [7:0] w_data [2];
  logic [5:0] ll0;
  logic [2:0] ll1;
  logic [7:0] rxq [2][$];
  logic [7:0] exp_q [2][$];
  int         len_q [2][$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         wr_cnt [2] = '{0, 0};
  int         pop_cyc [2] = '{0, 0};
  bit         armed [2] = '{0, 0};

  always #5 clk = ~clk;

  uart_line_editor dut0 (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty[0]), .r_data(r_data[0]),
    .rd_uart(rd_uart[0]), .tx_full(tx_full[0]), .wr_uart(wr_uart[0]), .w_data(w_data[0]),
    .line_done(line_done[0]), .line_len(ll0), .busy(busy[0])
  );
  uart_line_editor #(.LINE_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty[1]), .r_data(r_data[1]),
    .rd_uart(rd_uart[1]), .tx_full(tx_full[1]), .wr_uart(wr_uart[1]), .w_data(w_data[1]),
    .line_done(line_done[1]), .line_len(ll1), .busy(busy[1])
  );

  function automatic logic [31:0] get_len(int g);
    return g == 0 ? {26'b0, ll0} : {29'b0, ll1};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Receive FIFO model: pops on an observed rd_uart, presents the head byte.
  initial begin
    bit p [2];
    rx_empty = '{1'b1, 1'b1};
    r_data   = '{8'h00, 8'h00};
    forever begin
      @(negedge clk);
      p[0] = rd_uart[0];
      p[1] = rd_uart[1];
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (p[g] && rxq[g].size() > 0) void'(rxq[g].pop_front());
        rx_empty[g] = rxq[g].size() == 0;
        r_data[g]   = rx_empty[g] ? 8'h00 : rxq[g][0];
      end
    end
  end

  // Monitor: compares every accepted write and every line_done against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) armed[g] = 1'b0;
      chk($sformatf("rd_gate%0d", g), {31'b0, rd_uart[g] && rx_empty[g]}, 0);
      if (rd_uart[g]) begin
        armed[g]   = 1'b1;
        pop_cyc[g] = cyc;
      end
      if (wr_uart[g]) begin
        wr_cnt[g]++;
        if (armed[g]) begin
          chk($sformatf("latency%0d", g), cyc - pop_cyc[g], 2);
          armed[g] = 1'b0;
        end
        if (exp_q[g].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_extra%0d: got %h, expected no write", g, w_data[g]);
        end else chk($sformatf("tx_byte%0d", g), {24'b0, w_data[g]}, {24'b0, exp_q[g].pop_front()});
      end
      if (line_done[g]) begin
        if (len_q[g].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL line_done_extra%0d: got len %0d, expected no pulse", g, get_len(g));
        end else chk($sformatf("line_len%0d", g), get_len(g), len_q[g].pop_front());
      end
    end
  end

  task automatic feed(int g, logic [7:0] in [$], logic [7:0] ex [$], int ln);
    foreach (ex[i]) exp_q[g].push_back(ex[i]);
    if (ln >= 0) len_q[g].push_back(ln);
    foreach (in[i]) rxq[g].push_back(in[i]);
  endtask

  task automatic wait_idle(int g);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (k < 3000 && (exp_q[g].size() != 0 || len_q[g].size() != 0 || rxq[g].size() != 0 || busy[g]));
    chk($sformatf("drained%0d", g), exp_q[g].size() + len_q[g].size() + rxq[g].size(), 0);
    chk($sformatf("busy_idle%0d", g), {31'b0, busy[g]}, 0);
  endtask

  task automatic wait_wr(int g, int n);
    int k = 0;
    while (wr_cnt[g] < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("wr_reached%0d", g), wr_cnt[g] >= n, 1);
  endtask

  task automatic chk_reset_outs(int g);
    chk($sformatf("rst_rd%0d", g), {31'b0, rd_uart[g]}, 0);
    chk($sformatf("rst_wr%0d", g), {31'b0, wr_uart[g]}, 0);
    chk($sformatf("rst_done%0d", g), {31'b0, line_done[g]}, 0);
    chk($sformatf("rst_busy%0d", g), {31'b0, busy[g]}, 0);
    chk($sformatf("rst_wdata%0d", g), {24'b0, w_data[g]}, 0);
  endtask

  initial begin
    int base;
    tx_full = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    chk("rst_len0", get_len(0), 0);
    chk("rst_len1", get_len(1), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    feed(0, '{8'h61, 8'h62, 8'h0d}, '{8'h61, 8'h62, 8'h0d, 8'h0a, 8'h61, 8'h62, 8'h0d, 8'h0a}, 2);
    wait_idle(0);
    feed(0, '{8'h61, 8'h62, 8'h63, 8'h7f, 8'h0d},
         '{8'h61, 8'h62, 8'h63, 8'h08, 8'h20, 8'h08, 8'h0d, 8'h0a, 8'h61, 8'h62, 8'h0d, 8'h0a}, 2);
    wait_idle(0);
    feed(0, '{8'h08, 8'h0a}, '{8'h07}, -1);
    wait_idle(0);
    feed(0, '{8'h0d}, '{8'h0d, 8'h0a, 8'h0d, 8'h0a}, 0);
    wait_idle(0);
    feed(1, '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h0d},
         '{8'h61, 8'h62, 8'h63, 8'h64, 8'h07, 8'h0d, 8'h0a, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0d, 8'h0a}, 4);
    wait_idle(1);
    // Back-pressure in REPLAY: stall right after the first replayed byte is accepted.
    base = wr_cnt[0];
    feed(0, '{8'h61, 8'h62, 8'h63, 8'h0d},
         '{8'h61, 8'h62, 8'h63, 8'h0d, 8'h0a, 8'h61, 8'h62, 8'h63, 8'h0d, 8'h0a}, 3);
    wait_wr(0, base + 6);
    @(posedge clk);
    #1 tx_full[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("hold_wr", {31'b0, wr_uart[0]}, 0);
      chk("hold_data", {24'b0, w_data[0]}, 32'h62);
    end
    @(posedge clk);
    #1 tx_full[0] = 1'b0;
    wait_idle(0);
    // Reset mid-REPLAY: only the first five bytes of the old line may appear.
    base = wr_cnt[0];
    feed(0, '{8'h61, 8'h62, 8'h0d}, '{8'h61, 8'h62, 8'h0d, 8'h0a, 8'h61}, -1);
    wait_wr(0, base + 5);
    @(posedge clk);
    #1 reset_n = 1'b0;
    feed(0, '{8'h78, 8'h0d}, '{8'h78, 8'h0d, 8'h0a, 8'h78, 8'h0d, 8'h0a}, 1);
    repeat (3) @(negedge clk);
    chk("rst_rx_pending", {31'b0, rx_empty[0]}, 0);
    chk_reset_outs(0);
    chk("rst_len_mid", get_len(0), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle(0);
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("leftover%0d", g), exp_q[g].size() + len_q[g].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
